pipelined_adder: RTL

- Parametrised, pipelined add/subtract unit; successor to the 32-bit combinational adder used for PC+4 and branch-target generation.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, with a registered ripple carry between stages.
- Adds a valid/ready handshake, a subtract mode and status flags.
- Intended for the pipelined core's execute path and address generation, where a full-width combinational carry chain limits Fmax.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_chunk_stage.sv | 59 +++++
 rtl/pipelined_adder.sv | 90 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared defaults, the signed-overflow rule and the STAGES/WIDTH elaboration check
// used by pipelined_adder and its chunk stages.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Expands to a generate block that stops elaboration on an illegal pipeline split.
`define ADDER_CHECK_STAGES(W, S) \
   if ((S) < 1 || (S) > (W) || ((W) % (S)) != 0) begin : g_bad_stages \
      $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH"); \
   end

package adder_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

   // Two same-signed operands producing a result of the other sign.
   function automatic logic flag_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

`endif

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: sums chunk IDX of the skewed operands with the incoming carry
// and forwards operands, partial result, carry and valid under a shared enable.
module adder_chunk_stage
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] bx_in,
   input  logic [WIDTH-1:0] res_in,
   input  logic             carry_in,
   output logic [WIDTH-1:0] res_next,
   output logic             valid,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] bx_q,
   output logic [WIDTH-1:0] res_q,
   output logic             carry_q
);

   localparam int LO = IDX * CHUNK;

   logic [CHUNK:0] chunk_sum;

   always_comb begin
      // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
      res_next  = res_in;
      chunk_sum = {1'b0, a_in[LO +: CHUNK]} + {1'b0, bx_in[LO +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_in};
      res_next[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so each stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are cleared along with valid so a flushed pipe exposes zeros.
         valid   <= 1'b0;
         a_q     <= '0;
         bx_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else if (en) begin
         valid <= valid_in;
         // Bubbles leave the data registers untouched so the last result stays visible.
         if (valid_in) begin
            a_q     <= a_in;
            bx_q    <= bx_in;
            res_q   <= res_next;
            carry_q <= chunk_sum[CHUNK];
         end
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH bits split across STAGES ripple-carry stages,
// with a global-stall valid/ready handshake and registered carry/overflow/zero flags.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;

   `ADDER_CHECK_STAGES(WIDTH, STAGES)

   logic                         advance;
   logic [STAGES:0]              pipe_valid;
   logic [STAGES:0]              pipe_carry;
   logic [STAGES:0][WIDTH-1:0]   pipe_a;
   logic [STAGES:0][WIDTH-1:0]   pipe_bx;
   logic [STAGES:0][WIDTH-1:0]   pipe_res;
   logic [STAGES-1:0][WIDTH-1:0] res_next;

   // The whole pipe moves together; it only stalls when a result is waiting unclaimed.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtraction is a + ~b + 1, with the +1 entering as stage 0's carry.
   assign pipe_valid[0] = in_valid;
   assign pipe_a[0]     = a;
   assign pipe_bx[0]    = sub ? ~b : b;
   assign pipe_res[0]   = '0;
   assign pipe_carry[0] = sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_chunk_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (advance),
         .valid_in (pipe_valid[k]),
         .a_in     (pipe_a[k]),
         .bx_in    (pipe_bx[k]),
         .res_in   (pipe_res[k]),
         .carry_in (pipe_carry[k]),
         .res_next (res_next[k]),
         .valid    (pipe_valid[k+1]),
         .a_q      (pipe_a[k+1]),
         .bx_q     (pipe_bx[k+1]),
         .res_q    (pipe_res[k+1]),
         .carry_q  (pipe_carry[k+1])
      );
   end

   assign out_valid = pipe_valid[STAGES];
   assign sum       = pipe_res[STAGES];
   assign carry_out = pipe_carry[STAGES];

   // Flags are formed from the last stage's inputs so they register alongside sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (advance && pipe_valid[STAGES-1]) begin
         overflow <= flag_overflow(pipe_a[STAGES-1][WIDTH-1], pipe_bx[STAGES-1][WIDTH-1],
                                   res_next[STAGES-1][WIDTH-1]);
         zero     <= ~|res_next[STAGES-1];
      end
   end

   // Operand skew copies leaving the final stage have no consumer.
   logic unused;
   assign unused = ^{pipe_a[STAGES], pipe_bx[STAGES], res_next};

endmodule
